ins_mem_loader: RTL and testbench

- Write-side companion to the instruction memory, which is read-only, word-indexed (`addr>>2`) and 32 entries deep.
- Accepts a framed byte stream from a host/boot interface, assembles little-endian 32-bit instruction words, and drives a one-cycle write strobe per word into the instruction memory write port.
- Holds the CPU stalled while loading so fetch never sees a partially loaded program.

---
 rtl/ins_mem_loader_pkg.sv | 22 ++
 rtl/ins_mem_loader_word_assembler.sv | 44 ++++
 rtl/ins_mem_loader.sv | 160 ++++++++++++++++
 tb/tb_ins_mem_loader.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ins_mem_loader_pkg.sv
// ins_mem_pkg: shared types and constants for the instruction-memory loader.
//   state_t       loader FSM states
//   WORDS_DEFAULT default instruction-memory depth in words
//   BYTE_W        stream byte width
//   WORD_BYTES    bytes per instruction word
package ins_mem_pkg;

  localparam int WORDS_DEFAULT = 32;
  localparam int BYTE_W        = 8;
  localparam int WORD_BYTES    = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5,
    CHK   = 3'd6
  } state_t;

endpackage

// File: rtl/ins_mem_loader_word_assembler.sv
// word_assembler: packs little-endian stream bytes into a 32-bit word.
//   clk, rst_n  clock, asynchronous active-low reset
//   clear       resets the byte lane pointer and lane register
//   load        writes byte_in into the current lane and advances the pointer
//   byte_in     stream byte
//   word_next   lane register with byte_in merged into the current lane
//               (the complete word when full is high)
//   full        this load completes a word (pointer at the last lane)
module word_assembler
  import ins_mem_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         load,
  input  logic [BYTE_W-1:0]            byte_in,
  output logic [BYTE_W*WORD_BYTES-1:0] word_next,
  output logic                         full
);

  logic [1:0]                   byte_idx;
  logic [BYTE_W*WORD_BYTES-1:0] lanes;

  always_comb begin
    word_next = lanes;
    word_next[{byte_idx, 3'b000} +: BYTE_W] = byte_in;
  end

  assign full = load && (byte_idx == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx <= '0;
      lanes    <= '0;
    end else if (clear) begin
      byte_idx <= '0;
      lanes    <= '0;
    end else if (load) begin
      lanes    <= word_next;
      byte_idx <= byte_idx + 2'd1;
    end
  end

endmodule

// File: rtl/ins_mem_loader.sv
// ins_mem_loader: receives a framed byte stream (length byte N, then 4*N
// little-endian data bytes) and writes each assembled word into the
// instruction memory, stalling the CPU while a frame is in progress.
// Optional: INS_MEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 begins a frame (honoured in IDLE, DONE, ERR)
//   byte_in, byte_valid   stream input; byte_ready is the handshake reply
//   wr_en/wr_addr/wr_data instruction memory write port (byte address)
//   busy, cpu_stall       frame in progress
//   done, err             sticky frame outcome, cleared by next start
//
// state | meaning
// IDLE  | waiting for first start
// LEN   | accepting length byte
// DATA  | accepting data bytes of the current word
// WRITE | one-cycle write strobe for the assembled word
// CHK   | accepting checksum byte (checksum build only)
// DONE  | frame loaded successfully
// ERR   | bad length or checksum mismatch
module ins_mem_loader
  import ins_mem_pkg::*;
#(
  parameter int WORDS = WORDS_DEFAULT,
  parameter int CNT_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [31:0]       wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              cpu_stall,
  output logic              done,
  output logic              err
);

  localparam logic [BYTE_W-1:0] MAX_LEN = BYTE_W'(WORDS);

  state_t state_q, state_d;

  logic [CNT_W-1:0]             len_q;
  logic [CNT_W-1:0]             word_idx;
  logic [31:0]                  wr_addr_q;
  logic [BYTE_W*WORD_BYTES-1:0] wr_data_q;
  logic [BYTE_W*WORD_BYTES-1:0] word_next;
  logic                         word_full;
  logic                         asm_clear;
  logic                         asm_load;
  logic                         len_ok;
  logic                         last_word;

`ifdef INS_MEM_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] xor_q;
`endif

  // byte_ready depends only on state, so the handshake terms below carry no
  // combinational path back through the next-state logic.
`ifdef INS_MEM_LOADER_CHECKSUM_EN
  assign byte_ready = (state_q == LEN) || (state_q == DATA) || (state_q == CHK);
  assign busy       = (state_q == LEN) || (state_q == DATA) ||
                      (state_q == WRITE) || (state_q == CHK);
`else
  assign byte_ready = (state_q == LEN) || (state_q == DATA);
  assign busy       = (state_q == LEN) || (state_q == DATA) || (state_q == WRITE);
`endif

  assign cpu_stall = busy;
  assign wr_en     = (state_q == WRITE);
  assign done      = (state_q == DONE);
  assign err       = (state_q == ERR);
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;

  assign len_ok    = (byte_in != '0) && (byte_in <= MAX_LEN);
  assign last_word = (word_idx == len_q - 1'b1);
  assign asm_clear = (state_q == LEN) && byte_valid;
  assign asm_load  = (state_q == DATA) && byte_valid;

  word_assembler u_asm (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (asm_clear),
    .load     (asm_load),
    .byte_in  (byte_in),
    .word_next(word_next),
    .full     (word_full)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, ERR: if (start) state_d = LEN;
      LEN:   if (byte_valid) state_d = len_ok ? DATA : ERR;
      DATA:  if (word_full) state_d = WRITE;
      WRITE: begin
        if (last_word) begin
`ifdef INS_MEM_LOADER_CHECKSUM_EN
          state_d = CHK;
`else
          state_d = DONE;
`endif
        end else begin
          state_d = DATA;
        end
      end
`ifdef INS_MEM_LOADER_CHECKSUM_EN
      CHK:   if (byte_valid) state_d = (byte_in == xor_q) ? DONE : ERR;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Write port registers are loaded only when a word completes, so they stay
  // stable everywhere outside WRITE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q     <= '0;
      word_idx  <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      if (asm_clear && len_ok) begin
        len_q    <= byte_in[CNT_W-1:0];
        word_idx <= '0;
      end
      if (word_full) begin
        wr_addr_q <= {{(32-CNT_W-2){1'b0}}, word_idx, 2'b00};
        wr_data_q <= word_next;
      end
      if ((state_q == WRITE) && !last_word) begin
        word_idx <= word_idx + 1'b1;
      end
    end
  end

`ifdef INS_MEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xor_q <= '0;
    end else if (asm_clear) begin
      xor_q <= '0;
    end else if (asm_load) begin
      xor_q <= xor_q ^ byte_in;
    end
  end
`endif

endmodule

// File: tb/tb_ins_mem_loader.sv
// Scoreboard bench for ins_mem_loader: a frame-level reference model pushes
// expected writes into a queue; a monitor pops and compares on every wr_en.
module tb_ins_mem_loader;

  localparam int WORDS = 32;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        cpu_stall;
  logic        done;
  logic        err;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_checks = 0;
  int  n_fail = 0;

  always #5 clk = ~clk;

  ins_mem_loader #(.WORDS(WORDS), .CNT_W(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .byte_in   (byte_in),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .cpu_stall (cpu_stall),
    .done      (done),
    .err       (err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %h data %h, expected no write", wr_addr, wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", wr_addr, mon_e.addr);
        chk("wr_data", wr_data, mon_e.data);
        chk("byte_ready_in_write", {31'd0, byte_ready}, 32'd0);
      end
    end
  end

  // Reference model: from the whole frame, derive the writes and the outcome.
  function automatic bit model(input bq_t f, input int max_words);
    int  n;
    wr_t w;
`ifdef INS_MEM_LOADER_CHECKSUM_EN
    logic [7:0] x;
`endif
    n = int'(f[0]);
    if (n == 0 || n > WORDS) return 1'b1;
    for (int i = 0; i < n && i < max_words; i++) begin
      w.addr = 32'(i * 4);
      w.data = {f[4*i+4], f[4*i+3], f[4*i+2], f[4*i+1]};
      exp_q.push_back(w);
    end
`ifdef INS_MEM_LOADER_CHECKSUM_EN
    x = 8'h00;
    for (int i = 1; i <= 4 * n; i++) x = x ^ f[i];
    return f[4*n+1] != x;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bq_t build(input int n);
    bq_t        f;
    logic [7:0] b;
    logic [7:0] x;
    x = 8'h00;
    f.push_back(8'(n));
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      f.push_back(b);
      x = x ^ b;
    end
`ifdef INS_MEM_LOADER_CHECKSUM_EN
    f.push_back(x);
`endif
    return f;
  endfunction

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit got;
    byte_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    byte_in    = b;
    byte_valid = 1'b1;
    got        = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      got = byte_ready;
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL byte_timeout: byte_ready stayed 0, expected 1");
    end else begin
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
  endtask

  task automatic finish_frame(input bit exp_err);
    bit got;
    got = 1'b0;
    for (int c = 0; c < 30 && !got; c++) begin
      @(negedge clk);
      got = done | err;
    end
    chk("frame_end_seen", {31'd0, got}, 32'd1);
    chk("done", {31'd0, done}, {31'd0, !exp_err});
    chk("err", {31'd0, err}, {31'd0, exp_err});
    chk("busy", {31'd0, busy}, 32'd0);
    chk("cpu_stall", {31'd0, cpu_stall}, 32'd0);
    chk("pending_writes", 32'(exp_q.size()), 32'd0);
  endtask

  // gap < 0 selects a random 0..2 idle cycles before each byte.
  task automatic run(input bq_t f, input int gap);
    bit e;
    e = model(f, WORDS);
    pulse_start();
    for (int i = 0; i < f.size(); i++)
      send_byte(f[i], (gap < 0) ? int'($urandom_range(0, 2)) : gap);
    finish_frame(e);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_byte_ready"}, {31'd0, byte_ready}, 32'd0);
    chk({tag, "_wr_en"}, {31'd0, wr_en}, 32'd0);
    chk({tag, "_wr_addr"}, wr_addr, 32'd0);
    chk({tag, "_wr_data"}, wr_data, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_cpu_stall"}, {31'd0, cpu_stall}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  bq_t f;
  bit  dummy;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Single known word.
    f = '{8'h01, 8'h14, 8'h00, 8'hA0, 8'hE3};
`ifdef INS_MEM_LOADER_CHECKSUM_EN
    f.push_back(8'h57);
`endif
    run(f, 0);
    chk("single_word_data", wr_data, 32'hE3A00014);

    // Three words with byte_valid toggling every other cycle.
    run(build(3), 1);

    // Bad lengths; a later start clears err.
    f = '{8'h00};
    run(f, 0);
    pulse_start();
    chk("err_cleared_by_start", {31'd0, err}, 32'd0);
    chk("busy_after_restart", {31'd0, busy}, 32'd1);
    send_byte(8'd33, 0);
    finish_frame(1'b1);

    // Maximum frame.
    run(build(32), 0);
    chk("max_last_addr", wr_addr, 32'h7C);

    // Random frames with random gaps.
    for (int k = 0; k < 6; k++) run(build(int'($urandom_range(1, 8))), -1);

    // Asynchronous reset after 6 bytes of a 2-word frame.
    f = build(2);
    dummy = model(f, 1);
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(f[i], 0);
    chk("reset_pre_busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    chk("reset_pending_writes", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(build(2), -1);

`ifdef INS_MEM_LOADER_CHECKSUM_EN
    // Bad checksum: word written, then err.
    f = '{8'h01, 8'h14, 8'h00, 8'hA0, 8'hE3, 8'h00};
    run(f, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
